// File: rtl/wc_tile_loader.sv
// Serial-to-tile loader for an F(7,3) Winograd stage: gathers 9-sample tiles
// with stride 7 / overlap 2, zero-pads the tail of a row, and hands tiles off.
module wc_tile_loader #(
    parameter int W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [9*W-1:0]   D,
    output logic             t_valid,
    input  logic             t_ready,
    output logic             t_last,
    output logic [7:0]       t_idx
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [W-1:0] win_r [0:8];
    logic [3:0]   cnt_r;
    logic         pending_last_r;
    logic [7:0]   idx_r;
    logic         ready_r;
    logic         accept_s;

    // ready_r mirrors "state is FILL" but is held low while rst is asserted
    assign accept_s = s_valid & ready_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    if (cnt_r == 4'd8) begin
                        state_s = HOLD;
                    end else if (s_last) begin
                        state_s = PAD;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            PAD: begin
                if (cnt_r == 4'd8) begin
                    state_s = HOLD;
                end else begin
                    state_s = PAD;
                end
            end
            HOLD: begin
                if (t_ready) begin
                    state_s = FILL;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = FILL;
        endcase
    end

    // Registered input-side ready, derived from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= (state_s == FILL);
        end
    end

    // Window, fill count, row-end flag and tile index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                win_r[k] <= '0;
            end
            cnt_r          <= 4'd0;
            pending_last_r <= 1'b0;
            idx_r          <= 8'd0;
        end else begin
            case (state_r)
                FILL: begin
                    if (accept_s) begin
                        win_r[cnt_r] <= s_data;
                        cnt_r        <= cnt_r + 4'd1;
                        if (s_last) begin
                            pending_last_r <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    win_r[cnt_r] <= '0;
                    cnt_r        <= cnt_r + 4'd1;
                end
                HOLD: begin
                    if (t_ready) begin
                        if (pending_last_r) begin
                            // Row finished: start the next row from a clean window
                            for (int k = 0; k < 9; k++) begin
                                win_r[k] <= '0;
                            end
                            cnt_r          <= 4'd0;
                            idx_r          <= 8'd0;
                            pending_last_r <= 1'b0;
                        end else begin
                            win_r[0] <= win_r[7];
                            win_r[1] <= win_r[8];
                            cnt_r    <= 4'd2;
                            idx_r    <= idx_r + 8'd1;
                        end
                    end
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Element 0 (oldest) lands in the MSBs
    for (genvar k = 0; k < 9; k++) begin : g_pack
        assign D[9*W-1-k*W -: W] = win_r[k];
    end

    assign s_ready = ready_r;
    assign t_valid = (state_r == HOLD);
    assign t_last  = (state_r == HOLD) & pending_last_r;
    assign t_idx   = idx_r;

endmodule

// File: tb/tb_wc_tile_loader.sv
// Directed self-checking bench for wc_tile_loader: reset, single tile, stride/overlap,
// padding, backpressure and mid-row reset scenarios with hand-computed tiles.
module tb_wc_tile_loader;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   s_data;
    logic           s_valid;
    logic           s_last;
    logic           s_ready;
    logic [9*W-1:0] D;
    logic           t_valid;
    logic           t_ready;
    logic           t_last;
    logic [7:0]     t_idx;

    int tests_run = 0;
    int fails = 0;

    wc_tile_loader #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .D(D), .t_valid(t_valid), .t_ready(t_ready), .t_last(t_last), .t_idx(t_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [9*W-1:0] tile9(input int a0, input int a1, input int a2,
                                             input int a3, input int a4, input int a5,
                                             input int a6, input int a7, input int a8);
        return {a0[W-1:0], a1[W-1:0], a2[W-1:0], a3[W-1:0], a4[W-1:0],
                a5[W-1:0], a6[W-1:0], a7[W-1:0], a8[W-1:0]};
    endfunction

    // Present one sample, wait (bounded) for s_ready, let it be accepted; returns #1 after accept edge
    task automatic push(input int v, input logic last);
        int guard;
        guard = 0;
        s_data  = v[W-1:0];
        s_last  = last;
        s_valid = 1'b1;
        while (!s_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        tests_run++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL push_ready: sample %0d s_ready=%b required 1", v, s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; t_ready = 1'b0;
        #3;
        tests_run++;
        if (s_ready !== 1'b0 || t_valid !== 1'b0 || t_last !== 1'b0 || D !== '0) begin
            fails++;
            $display("FAIL reset_outputs: s_ready=%b t_valid=%b t_last=%b D=%h required 0,0,0,0",
                     s_ready, t_valid, t_last, D);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (s_ready !== 1'b1 || t_valid !== 1'b0 || t_idx !== 8'd0) begin
            fails++;
            $display("FAIL reset_release: s_ready=%b t_valid=%b t_idx=%0d required 1,0,0",
                     s_ready, t_valid, t_idx);
        end
    endtask

    task automatic test_single_tile();
        int vals[9] = '{2, -10, 3, 4, -13, -18, -16, -28, -11};
        logic [9*W-1:0] exp_d;
        exp_d = {10'h002, 10'h3F6, 10'h003, 10'h004, 10'h3F3,
                 10'h3EE, 10'h3F0, 10'h3E4, 10'h3F5};
        do_reset();
        t_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(vals[i], 1'b0);
        tests_run++;
        if (t_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_early_valid: t_valid=%b required 0", t_valid);
        end
        push(vals[8], 1'b0);
        tests_run++;
        if (t_valid !== 1'b1 || D !== exp_d || t_last !== 1'b0 || t_idx !== 8'd0 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_tile: t_valid=%b D=%h t_last=%b t_idx=%0d s_ready=%b required 1,%h,0,0,0",
                     t_valid, D, t_last, t_idx, s_ready, exp_d);
        end
        @(posedge clk); #1;
        tests_run++;
        if (t_valid !== 1'b0 || t_idx !== 8'd1 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_handshake: t_valid=%b t_idx=%0d s_ready=%b required 0,1,1",
                     t_valid, t_idx, s_ready);
        end
    endtask

    task automatic test_stride_row();
        do_reset();
        t_ready = 1'b1;
        for (int i = 1; i <= 9; i++) push(i, 1'b0);
        tests_run++;
        if (t_valid !== 1'b1 || D !== tile9(1, 2, 3, 4, 5, 6, 7, 8, 9) || t_idx !== 8'd0 || t_last !== 1'b0) begin
            fails++;
            $display("FAIL stride_tile0: t_valid=%b D=%h t_idx=%0d t_last=%b required 1,%h,0,0",
                     t_valid, D, t_idx, t_last, tile9(1, 2, 3, 4, 5, 6, 7, 8, 9));
        end
        for (int i = 10; i <= 16; i++) push(i, (i == 16));
        // Tile must appear straight after the 16th accept: no padding cycles
        tests_run++;
        if (t_valid !== 1'b1 || D !== tile9(8, 9, 10, 11, 12, 13, 14, 15, 16) || t_idx !== 8'd1 || t_last !== 1'b1) begin
            fails++;
            $display("FAIL stride_tile1: t_valid=%b D=%h t_idx=%0d t_last=%b required 1,%h,1,1",
                     t_valid, D, t_idx, t_last, tile9(8, 9, 10, 11, 12, 13, 14, 15, 16));
        end
        @(posedge clk); #1;
        tests_run++;
        if (t_valid !== 1'b0 || t_idx !== 8'd0 || s_ready !== 1'b1 || D !== '0) begin
            fails++;
            $display("FAIL stride_row_end: t_valid=%b t_idx=%0d s_ready=%b D=%h required 0,0,1,0",
                     t_valid, t_idx, s_ready, D);
        end
    endtask

    task automatic test_pad_backpressure();
        int cycles;
        logic [9*W-1:0] exp_pad;
        exp_pad = tile9(8, 9, 10, 11, 12, 0, 0, 0, 0);
        do_reset();
        t_ready = 1'b1;
        for (int i = 1; i <= 9; i++) push(i, 1'b0);
        tests_run++;
        if (D !== tile9(1, 2, 3, 4, 5, 6, 7, 8, 9) || t_valid !== 1'b1) begin
            fails++;
            $display("FAIL pad_tile0: D=%h t_valid=%b required %h,1", D, t_valid, tile9(1, 2, 3, 4, 5, 6, 7, 8, 9));
        end
        push(10, 1'b0);
        t_ready = 1'b0;
        push(11, 1'b0);
        push(12, 1'b1);
        cycles = 0;
        while (!t_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        tests_run++;
        if (cycles !== 4 || t_valid !== 1'b1) begin
            fails++;
            $display("FAIL pad_cycles: saw %0d cycles t_valid=%b required 4,1", cycles, t_valid);
        end
        tests_run++;
        if (D !== exp_pad || t_last !== 1'b1 || t_idx !== 8'd1) begin
            fails++;
            $display("FAIL pad_tile1: D=%h t_last=%b t_idx=%0d required %h,1,1", D, t_last, t_idx, exp_pad);
        end
        // Downstream stalls while a new sample waits at the input
        s_data = 10'd21;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (t_valid !== 1'b1 || D !== exp_pad || t_last !== 1'b1 || t_idx !== 8'd1 || s_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_stable[%0d]: t_valid=%b D=%h t_last=%b t_idx=%0d s_ready=%b required 1,%h,1,1,0",
                         i, t_valid, D, t_last, t_idx, s_ready, exp_pad);
            end
        end
        t_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (t_valid !== 1'b0 || s_ready !== 1'b1 || t_idx !== 8'd0) begin
            fails++;
            $display("FAIL stall_release: t_valid=%b s_ready=%b t_idx=%0d required 0,1,0", t_valid, s_ready, t_idx);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        for (int i = 22; i <= 28; i++) push(i, 1'b0);
        tests_run++;
        if (t_valid !== 1'b0) begin
            fails++;
            $display("FAIL newrow_early: t_valid=%b after 8 samples required 0", t_valid);
        end
        push(29, 1'b0);
        tests_run++;
        if (t_valid !== 1'b1 || D !== tile9(21, 22, 23, 24, 25, 26, 27, 28, 29) || t_idx !== 8'd0 || t_last !== 1'b0) begin
            fails++;
            $display("FAIL newrow_tile: t_valid=%b D=%h t_idx=%0d t_last=%b required 1,%h,0,0",
                     t_valid, D, t_idx, t_last, tile9(21, 22, 23, 24, 25, 26, 27, 28, 29));
        end
    endtask

    task automatic test_reset_mid_row();
        int cycles;
        do_reset();
        t_ready = 1'b1;
        for (int i = 50; i <= 54; i++) push(i, 1'b0);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (s_ready !== 1'b0 || t_valid !== 1'b0 || D !== '0) begin
            fails++;
            $display("FAIL midrst_outputs: s_ready=%b t_valid=%b D=%h required 0,0,0", s_ready, t_valid, D);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 60; i <= 68; i++) push(i, 1'b0);
        tests_run++;
        if (t_valid !== 1'b1 || D !== tile9(60, 61, 62, 63, 64, 65, 66, 67, 68) || t_idx !== 8'd0 || t_last !== 1'b0) begin
            fails++;
            $display("FAIL midrst_tile: t_valid=%b D=%h t_idx=%0d t_last=%b required 1,%h,0,0",
                     t_valid, D, t_idx, t_last, tile9(60, 61, 62, 63, 64, 65, 66, 67, 68));
        end
        do_reset();
        push(7, 1'b1);
        cycles = 0;
        while (!t_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        tests_run++;
        if (t_valid !== 1'b1 || cycles !== 8 || D !== tile9(7, 0, 0, 0, 0, 0, 0, 0, 0) || t_last !== 1'b1 || t_idx !== 8'd0) begin
            fails++;
            $display("FAIL single_last: t_valid=%b pad_cycles=%0d D=%h t_last=%b t_idx=%0d required 1,8,%h,1,0",
                     t_valid, cycles, D, t_last, t_idx, tile9(7, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_stride_row();
        test_pad_backpressure();
        test_reset_mid_row();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
